// File: rtl/cluster_pkg.sv
// cluster_pkg: shared definitions for the cluster merger output path.
// Holds default cluster field widths, the empty-slot address marker,
// the cluster record type and the serializer state encoding.
package cluster_pkg;

   localparam int                MXADRBITS   = 11;
   localparam int                MXCNTBITS   = 3;
   localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FE;

   typedef struct packed {
      logic [MXADRBITS-1:0] adr;
      logic [MXCNTBITS-1:0] cnt;
   } cluster_t;

   typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/cluster_frame_serializer_popcount8.sv
// popcount8: combinational population count of an 8-bit mask.
// Ports:
//   i_mask  [7:0]  input mask
//   o_count [3:0]  number of set bits (0..8)
module popcount8 (
   input  logic [7:0] i_mask,
   output logic [3:0] o_count
);

   always_comb begin
      o_count = 4'd0;
      for (int i = 0; i < 8; i++) o_count = o_count + 4'(i_mask[i]);
   end

endmodule

// File: rtl/cluster_frame_serializer.sv
// cluster_frame_serializer: latches the merger's eight clusters on the frame
// pulse and streams them out two per clock4x cycle over four cycles.
// Optional feature macro: FRAME_BX_EN (12-bit per-frame counter on frame_bx_o;
// when undefined frame_bx_o is tied to 0).
// Ports:
//   clock4x        clock, 4x bunch-crossing rate
//   reset          synchronous active-high reset
//   mux_pulse_in   one-cycle frame pulse aligned with adr_in/cnt_in
//   adr_in/cnt_in  eight packed slots, slot k at [k*W +: W]
//   adr*/cnt*/vpf* lane 0 / lane 1 cluster and valid flag
//   frame_start_o  first pair of a frame
//   phase_o        pair index on the lanes (0..3)
//   nclusters_o    valid clusters in the current frame
//   sync_err_o     sticky early-pulse flag
//   frame_bx_o     frame counter value for the current frame
module cluster_frame_serializer #(
   parameter int                    MXADRBITS   = cluster_pkg::MXADRBITS,
   parameter int                    MXCNTBITS   = cluster_pkg::MXCNTBITS,
   parameter logic [MXADRBITS-1:0]  INVALID_ADR = cluster_pkg::INVALID_ADR
)(
   input  logic                   clock4x,
   input  logic                   reset,
   input  logic                   mux_pulse_in,
   input  logic [8*MXADRBITS-1:0] adr_in,
   input  logic [8*MXCNTBITS-1:0] cnt_in,
   output logic [MXADRBITS-1:0]   adr0_o,
   output logic [MXADRBITS-1:0]   adr1_o,
   output logic [MXCNTBITS-1:0]   cnt0_o,
   output logic [MXCNTBITS-1:0]   cnt1_o,
   output logic                   vpf0_o,
   output logic                   vpf1_o,
   output logic                   frame_start_o,
   output logic [1:0]             phase_o,
   output logic [3:0]             nclusters_o,
   output logic                   sync_err_o,
   output logic [11:0]            frame_bx_o
);
   import cluster_pkg::*;

   // Local record sized by this instance's parameters.
   typedef struct packed {
      logic [MXADRBITS-1:0] adr;
      logic [MXCNTBITS-1:0] cnt;
   } slot_t;

   slot_t        w_slot [8];
   logic [7:0]   w_vmask;
   logic [3:0]   w_ncnt;
   logic [1:0]   w_nphase;
   logic [2:0]   w_idx0, w_idx1;

   slot_t        r_buf [8];
   logic [7:0]   r_vmask;
   state_t       r_state;
   logic [1:0]   r_phase;

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         w_slot[k].adr = adr_in[k*MXADRBITS +: MXADRBITS];
         w_slot[k].cnt = cnt_in[k*MXCNTBITS +: MXCNTBITS];
         w_vmask[k]    = (w_slot[k].adr != INVALID_ADR);
      end
   end

   popcount8 u_popcount8 (
      .i_mask  (w_vmask),
      .o_count (w_ncnt)
   );

   // Outputs are registered, so each update loads the pair for the phase
   // that becomes visible next.
   assign w_nphase = r_phase + 2'd1;
   assign w_idx0   = {w_nphase, 1'b0};
   assign w_idx1   = {w_nphase, 1'b1};
   assign phase_o  = r_phase;

   always_ff @(posedge clock4x) begin
      if (reset) begin
         r_state       <= IDLE;
         r_phase       <= 2'd0;
         r_vmask       <= 8'd0;
         frame_start_o <= 1'b0;
         nclusters_o   <= 4'd0;
         sync_err_o    <= 1'b0;
         adr0_o        <= INVALID_ADR;
         adr1_o        <= INVALID_ADR;
         cnt0_o        <= '0;
         cnt1_o        <= '0;
         vpf0_o        <= 1'b0;
         vpf1_o        <= 1'b0;
      end else if (mux_pulse_in) begin
         for (int k = 0; k < 8; k++) r_buf[k] <= w_slot[k];
         r_vmask       <= w_vmask;
         nclusters_o   <= w_ncnt;
         // A pulse before the last pair is out means the frame grid slipped.
         if (r_state == SEND && r_phase != 2'd3) sync_err_o <= 1'b1;
         r_state       <= SEND;
         r_phase       <= 2'd0;
         frame_start_o <= 1'b1;
         // Pair 0 goes straight from the inputs to hit the N+1 slot.
         adr0_o        <= w_slot[0].adr;
         cnt0_o        <= w_slot[0].cnt;
         vpf0_o        <= w_vmask[0];
         adr1_o        <= w_slot[1].adr;
         cnt1_o        <= w_slot[1].cnt;
         vpf1_o        <= w_vmask[1];
      end else if (r_state == SEND && r_phase != 2'd3) begin
         r_phase       <= w_nphase;
         frame_start_o <= 1'b0;
         adr0_o        <= r_buf[w_idx0].adr;
         cnt0_o        <= r_buf[w_idx0].cnt;
         vpf0_o        <= r_vmask[w_idx0];
         adr1_o        <= r_buf[w_idx1].adr;
         cnt1_o        <= r_buf[w_idx1].cnt;
         vpf1_o        <= r_vmask[w_idx1];
      end else begin
         r_state       <= IDLE;
         r_phase       <= 2'd0;
         frame_start_o <= 1'b0;
         nclusters_o   <= 4'd0;
         adr0_o        <= INVALID_ADR;
         adr1_o        <= INVALID_ADR;
         cnt0_o        <= '0;
         cnt1_o        <= '0;
         vpf0_o        <= 1'b0;
         vpf1_o        <= 1'b0;
      end
   end

`ifdef FRAME_BX_EN
   logic [11:0] r_bx_cnt;

   // Output shows the pre-increment count for the whole frame; wraps at 4096.
   always_ff @(posedge clock4x) begin
      if (reset) begin
         r_bx_cnt   <= 12'd0;
         frame_bx_o <= 12'd0;
      end else if (mux_pulse_in) begin
         frame_bx_o <= r_bx_cnt;
         r_bx_cnt   <= r_bx_cnt + 12'd1;
      end
   end
`else
   assign frame_bx_o = 12'd0;
`endif

endmodule

// File: doc/cluster_frame_serializer.md
# cluster_frame_serializer

Downstream stage of the 16→8 cluster merger. The merger delivers its eight clusters once per bunch crossing; this block latches those eight clusters when the frame pulse arrives and streams them out as two clusters per `clock4x` cycle over four cycles. It also flags which slots hold valid clusters, reports the per-frame cluster count, and detects frame-pulse misalignment. Its output feeds the link formatter.

## Interface
Parameters:
- `MXADRBITS`, default 11: cluster address width.
- `MXCNTBITS`, default 3: cluster size width.
- `INVALID_ADR`, default 11'h7FE: address value that marks an empty slot.

Ports:
- `clock4x`  in  1  single clock, 4× bunch-crossing rate.
- `reset`  in  1  synchronous, active-high.
- `mux_pulse_in`  in  1  one-cycle frame pulse, aligned with the merger's cluster outputs.
- `adr_in`  in  8·MXADRBITS  packed addresses; slot k is at bits [k·MXADRBITS +: MXADRBITS].
- `cnt_in`  in  8·MXCNTBITS  packed sizes, same slot layout as `adr_in`.
- `adr0_o`, `adr1_o`  out  MXADRBITS  lane 0 / lane 1 address.
- `cnt0_o`, `cnt1_o`  out  MXCNTBITS  lane 0 / lane 1 size.
- `vpf0_o`, `vpf1_o`  out  1  lane valid.
- `frame_start_o`  out  1  high on the first pair of each frame.
- `phase_o`  out  2  index of the pair currently on the lanes (0..3).
- `nclusters_o`  out  4  number of valid clusters in the current frame (0..8).
- `sync_err_o`  out  1  sticky frame-misalignment flag.
- `frame_bx_o`  out  12  frame counter (see Configuration).

## Operation
- A slot is valid when its address ≠ `INVALID_ADR`. The size field plays no part in validity.
- On a cycle with `mux_pulse_in` = 1:
  - all 8 slots are copied into the frame buffer;
  - the valid mask is computed and stored;
  - `nclusters` is the popcount of the valid mask.
- State machine: IDLE ↔ SEND, with a 2-bit phase counter.
  - IDLE + pulse → SEND, phase 0.
  - SEND with phase < 3: phase increments.
  - SEND, phase 3, pulse in that cycle → SEND, phase 0 (back-to-back frames, the nominal case).
  - SEND, phase 3, no pulse → IDLE.
- In SEND at phase p:
  - lane 0 carries slot 2p; lane 1 carries slot 2p+1;
  - each lane's `vpf` equals that slot's valid bit.
- In IDLE:
  - lanes output `adr = INVALID_ADR`, `cnt = 0`, `vpf = 0`;
  - `phase_o` = 0, `frame_start_o` = 0, `nclusters_o` = 0.
- Early pulse (SEND, phase 0..2, pulse high):
  - the remaining pairs of the old frame are dropped;
  - the new frame is captured and sent from phase 0;
  - `sync_err_o` is set.
- `sync_err_o` clears only on `reset`.
- Reset mid-frame: the frame is dropped immediately and the block enters IDLE. A pulse in the same cycle as `reset` is ignored.

## Timing
- Pulse at cycle N → pair 0 and `frame_start_o` at N+1; pair 3 at N+4.
- All outputs are registered.
- `nclusters_o` is valid from N+1 and is held for all four phases.
- `sync_err_o` rises one cycle after the offending pulse.
- Reset values:
  - `adr*_o` = `INVALID_ADR`;
  - `cnt*_o` = 0, `vpf*_o` = 0;
  - `frame_start_o` = 0, `phase_o` = 0, `nclusters_o` = 0;
  - `sync_err_o` = 0, `frame_bx_o` = 0.

## Configuration
- Macro: `FRAME_BX_EN`.
- Defined:
  - a 12-bit counter increments on every captured frame and wraps 4095 → 0;
  - `frame_bx_o` presents the pre-increment value, aligned with the frame's phases 0..3;
  - the first frame after reset carries 0.
- Undefined: `frame_bx_o` is tied to 0 and no counter is synthesised.

## Structure
- Shared package `cluster_pkg` holds:
  - `MXADRBITS`, `MXCNTBITS` and `INVALID_ADR`;
  - the `cluster_t` struct {adr, cnt};
  - the state enum {IDLE, SEND}.
- One sub-module: `popcount8` (8-bit mask → 4-bit count), combinational, instantiated at capture.

## Test plan
- Single frame, slots 0..7 with adr 10..17 and cnt 1..7,0, pulse at cycle 5:
  - cycles 6..9 show pairs (10,11), (12,13), (14,15), (16,17), all `vpf` = 1;
  - `nclusters_o` = 8; `frame_start_o` only at cycle 6; IDLE outputs at cycle 10.
- Partial frame, slots 0..2 valid and slots 3..7 = 0x7FE:
  - `nclusters_o` = 3;
  - phase 1 shows `vpf0_o` = 1, `vpf1_o` = 0; phases 2..3 have both `vpf` = 0.
- Pulses every 4 cycles for 10 frames:
  - phases run continuously 0..3 with no IDLE gap;
  - `sync_err_o` stays 0;
  - with `FRAME_BX_EN`, `frame_bx_o` steps 0..9.
- Pulse at N then again at N+2:
  - the first frame stops after phase 1;
  - the second frame starts at N+3;
  - `sync_err_o` = 1 from N+3 and holds until `reset`.
- `reset` asserted during phase 2:
  - the next cycle shows all reset values;
  - a pulse coincident with `reset` produces no frame.
- With `FRAME_BX_EN` and 4097 back-to-back frames: the last frame shows `frame_bx_o` = 0 after the wrap.
